// File: rtl/dmem_pkg.sv
// Shared sizing and types for the MIPS data memory.
package dmem_pkg;
    localparam int DMEM_DATA_WIDTH = 32;
    localparam int DMEM_ADDR_WIDTH = 6;
    localparam int DMEM_DEPTH      = 2 ** DMEM_ADDR_WIDTH;

    typedef logic [DMEM_DATA_WIDTH-1:0] word_t;
    typedef logic [DMEM_ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/mips_data_memory.sv
// Word-addressed data memory: synchronous write, combinational gated read.
// DMEM_PRELOAD_EN: reset loads mem[i] = i instead of zero.
module mips_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Reset wins over a coincident write; the whole array is (re)initialised.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef DMEM_PRELOAD_EN
                mem_q[i] <= DATA_WIDTH'(i);
`else
                mem_q[i] <= '0;
`endif
            end
        end else if (mem_write) begin
            mem_q[address] <= write_data;
        end
    end

    // No write bypass: a same-address write shows up only after the edge.
    assign read_data = mem_read ? mem_q[address] : '0;

endmodule

// File: tb/tb_mips_data_memory.sv
// Self-checking bench for mips_data_memory: directed cases plus random traffic
// checked against an array model; honours DMEM_PRELOAD_EN.
module tb_mips_data_memory;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [5:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [64];

    mips_data_memory dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rst_val(input int i);
`ifdef DMEM_PRELOAD_EN
        return 32'(i);
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Apply inputs mid-cycle, check the combinational read, then clock and update the model.
    task automatic step(input string tag, input logic rst, input logic wr, input logic rd,
                        input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = rst; mem_write = wr; mem_read = rd; address = a; write_data = d;
        #1;
        chk(tag, read_data, rd ? model[a] : 32'd0);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 64; i++) model[i] = rst_val(i);
        end else if (wr) begin
            model[a] = d;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model[i] = '0;

        step("reset_rd0", 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
        chk("reset_rd0_after", read_data, 32'd0);

        // 1: reset contents
        step("t1_read1", 1'b0, 1'b0, 1'b1, 6'd1, 32'd0);
        chk("t1_const", read_data, rst_val(1));
        step("t1_read0", 1'b0, 1'b0, 1'b1, 6'd0, 32'd0);
        step("t1_read63", 1'b0, 1'b0, 1'b1, 6'd63, 32'd0);
        chk("t1_63_const", read_data, rst_val(63));

        // 2, 3, 4: write, read back, neighbours, read gate
        step("t2_write", 1'b0, 1'b1, 1'b0, 6'd2, 32'd50);
        step("t2_read", 1'b0, 1'b0, 1'b1, 6'd2, 32'd0);
        chk("t2_const", read_data, 32'd50);
        step("t3_read3", 1'b0, 1'b0, 1'b1, 6'd3, 32'd0);
        chk("t3_const", read_data, rst_val(3));
        step("t3_read1", 1'b0, 1'b0, 1'b1, 6'd1, 32'd0);
        chk("t3_nb1_const", read_data, rst_val(1));
        step("t4_gate", 1'b0, 1'b0, 1'b0, 6'd2, 32'd0);
        chk("t4_const", read_data, 32'd0);

        // mem_write=0 leaves the array alone even with data present
        step("nowr", 1'b0, 1'b0, 1'b0, 6'd2, 32'h1234_5678);
        step("nowr_rd", 1'b0, 1'b0, 1'b1, 6'd2, 32'd0);
        chk("nowr_const", read_data, 32'd50);

        // 5: reset beats a coincident write
        step("t5_pre", 1'b0, 1'b1, 1'b0, 6'd5, 32'd99);
        step("t5_rstwr", 1'b1, 1'b1, 1'b1, 6'd5, 32'd7);
        step("t5_read", 1'b0, 1'b0, 1'b1, 6'd5, 32'd0);
        chk("t5_const", read_data, rst_val(5));
        step("t5_read2", 1'b0, 1'b0, 1'b1, 6'd2, 32'd0);
        chk("t5_cleared2", read_data, rst_val(2));

        // 6: same-address read/write, old before edge, new after
        step("t6_before", 1'b0, 1'b1, 1'b1, 6'd63, 32'hDEAD_BEEF);
        chk("t6_after", read_data, 32'hDEAD_BEEF);
        step("t6_hold", 1'b0, 1'b0, 1'b1, 6'd63, 32'd0);

        // Random traffic, addresses biased toward the ends of the range
        for (int n = 0; n < 600; n++) begin
            logic [5:0]  a;
            logic [31:0] d;
            logic        rst, wr, rd;
            case ($urandom_range(0, 7))
                0:       a = 6'd0;
                1:       a = 6'd63;
                default: a = 6'($urandom_range(0, 63));
            endcase
            d   = $urandom;
            rst = ($urandom_range(0, 49) == 0);
            wr  = $urandom_range(0, 1) == 1;
            rd  = $urandom_range(0, 3) != 0;
            step("rand", rst, wr, rd, a, d);
        end

        // Final sweep of every word
        for (int i = 0; i < 64; i++) step("sweep", 1'b0, 1'b0, 1'b1, 6'(i), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
